trial_sequencer: RTL and testbench

Multi-trial session controller for the reaction-time tester. It runs a session of TRIALS back-to-back reaction trials. For each trial it pulses the random-delay generator, waits for the delay to expire, waits for the reaction or a timeout, then captures the counter value. At session end it reports last, best and average times plus a miss count, and the display path (seven-segment and LED matrix) reads these results.

---
 rtl/trial_if.sv | 33 +++
 rtl/trial_sequencer.sv | 153 +++++++++++++++
 tb/tb_trial_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trial_if.sv
// Session control and result bus of the reaction-time trial sequencer.
interface trial_if #(
   parameter int LOG2_TRIALS = 2,
   parameter int TIME_W      = 16
);
   logic                   go;
   logic                   abort;
   logic                   resp;
   logic                   delay_done;
   logic                   timeout;
   logic [TIME_W-1:0]      act_time;
   logic                   trial_start;
   logic                   busy;
   logic                   done;
   logic                   early;
   logic [LOG2_TRIALS-1:0] trial_idx;
   logic [TIME_W-1:0]      last_time;
   logic [TIME_W-1:0]      best_time;
   logic [TIME_W-1:0]      avg_time;
   logic [LOG2_TRIALS:0]   miss_cnt;

   modport master (
      output go, abort, resp, delay_done, timeout, act_time,
      input  trial_start, busy, done, early, trial_idx,
      input  last_time, best_time, avg_time, miss_cnt
   );

   modport slave (
      input  go, abort, resp, delay_done, timeout, act_time,
      output trial_start, busy, done, early, trial_idx,
      output last_time, best_time, avg_time, miss_cnt
   );
endinterface

// File: rtl/trial_sequencer.sv
// Multi-trial session controller: arms each trial, captures reaction times,
// and reports last, best and average time plus the miss count.
module trial_sequencer #(
   parameter int TRIALS      = 4,
   parameter int LOG2_TRIALS = 2,
   parameter int TIME_W      = 16,
   parameter int GAP_CYCLES  = 50000000,
   parameter int PENALTY     = 9999
) (
   input logic clk,
   input logic rst_n,
   trial_if.slave bus
);
   localparam int SW = TIME_W + LOG2_TRIALS;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [GW-1:0] GAP_ONE = GW'(1);
   localparam logic [LOG2_TRIALS-1:0] IDX_LAST = LOG2_TRIALS'(TRIALS - 1);
   localparam logic [LOG2_TRIALS-1:0] IDX_ONE = LOG2_TRIALS'(1);
   localparam logic [LOG2_TRIALS:0] MISS_ONE = (LOG2_TRIALS + 1)'(1);
   localparam logic [SW-1:0] PEN = SW'(PENALTY);

   typedef enum logic [2:0] {
      IDLE, ARM, WAIT_DELAY, MEASURE, CAPTURE, GAP, DONE
   } state_t;

   state_t                 state;
   logic                   go_q;
   logic                   resp_q;
   logic                   live;
   logic [GW-1:0]          gap_cnt;
   logic [SW-1:0]          sum;
   logic                   trial_start;
   logic                   busy;
   logic                   done;
   logic                   early;
   logic [LOG2_TRIALS-1:0] trial_idx;
   logic [TIME_W-1:0]      last_time;
   logic [TIME_W-1:0]      best_time;
   logic [TIME_W-1:0]      avg_time;
   logic [LOG2_TRIALS:0]   miss_cnt;
   logic                   go_edge;
   logic                   resp_edge;

   // live blocks a go level held through reset release from reading as an edge
   assign go_edge   = bus.go & ~go_q & live;
   assign resp_edge = bus.resp & ~resp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         go_q        <= 1'b0;
         resp_q      <= 1'b0;
         live        <= 1'b0;
         gap_cnt     <= '0;
         sum         <= '0;
         trial_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         early       <= 1'b0;
         trial_idx   <= '0;
         last_time   <= '0;
         best_time   <= '1;
         avg_time    <= '0;
         miss_cnt    <= '0;
      end else begin
         go_q        <= bus.go;
         resp_q      <= bus.resp;
         live        <= 1'b1;
         trial_start <= 1'b0;
         early       <= 1'b0;
         if (bus.abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
         end else begin
            unique case (state)
               IDLE, DONE: begin
                  if (go_edge) begin
                     sum         <= '0;
                     miss_cnt    <= '0;
                     trial_idx   <= '0;
                     last_time   <= '0;
                     avg_time    <= '0;
                     best_time   <= '1;
                     busy        <= 1'b1;
                     done        <= 1'b0;
                     trial_start <= 1'b1;
                     state       <= ARM;
                  end
               end
               ARM: state <= WAIT_DELAY;
               WAIT_DELAY: begin
                  if (resp_edge) begin
                     early    <= 1'b1;
                     miss_cnt <= miss_cnt + MISS_ONE;
                     sum      <= sum + PEN;
                     gap_cnt  <= '0;
                     state    <= GAP;
                  end else if (bus.delay_done) begin
                     state <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (bus.timeout) begin
                     miss_cnt <= miss_cnt + MISS_ONE;
                     sum      <= sum + PEN;
                     gap_cnt  <= '0;
                     state    <= GAP;
                  end else if (resp_edge) begin
                     state <= CAPTURE;
                  end
               end
               CAPTURE: begin
                  last_time <= bus.act_time;
                  sum       <= sum + SW'(bus.act_time);
                  if (bus.act_time < best_time)
                     best_time <= bus.act_time;
                  gap_cnt <= '0;
                  state   <= GAP;
               end
               GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     if (trial_idx == IDX_LAST) begin
                        avg_time <= TIME_W'(sum >> LOG2_TRIALS);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                     end else begin
                        trial_idx   <= trial_idx + IDX_ONE;
                        trial_start <= 1'b1;
                        state       <= ARM;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + GAP_ONE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.trial_start = trial_start;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.early       = early;
   assign bus.trial_idx   = trial_idx;
   assign bus.last_time   = last_time;
   assign bus.best_time   = best_time;
   assign bus.avg_time    = avg_time;
   assign bus.miss_cnt    = miss_cnt;
endmodule

// File: tb/tb_trial_sequencer.sv
// Bench for trial_sequencer: session table with a result scoreboard,
// plus abort and asynchronous-reset sequences.
module tb_trial_sequencer;
   localparam int TW = 16;
   localparam int HIT = 0, EARLY = 1, MISS = 2, TIE = 3;
   localparam int NS = 5;

   typedef struct packed {
      logic [3:0][1:0]  kind;
      logic [3:0][15:0] t;
      logic [15:0]      last;
      logic [15:0]      best;
      logic [15:0]      avg;
      logic [2:0]       miss;
      logic [2:0]       nearly;
   } sess_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   early_seen = 0;
   sess_t tbl [NS];
   sess_t exp_q [$];

   always #5 clk = ~clk;

   trial_if #(.LOG2_TRIALS(2), .TIME_W(TW)) bus ();

   trial_sequencer #(
      .TRIALS(4), .LOG2_TRIALS(2), .TIME_W(TW),
      .GAP_CYCLES(4), .PENALTY(9999)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always @(negedge clk)
      if (rst_n && bus.early) early_seen++;

   function automatic sess_t mk(
      int k0, int t0, int k1, int t1, int k2, int t2, int k3, int t3,
      int last, int best, int avg, int miss, int ne);
      sess_t s;
      s.kind[0] = 2'(k0); s.t[0] = 16'(t0);
      s.kind[1] = 2'(k1); s.t[1] = 16'(t1);
      s.kind[2] = 2'(k2); s.t[2] = 16'(t2);
      s.kind[3] = 2'(k3); s.t[3] = 16'(t3);
      s.last = 16'(last);
      s.best = 16'(best);
      s.avg = 16'(avg);
      s.miss = 3'(miss);
      s.nearly = 3'(ne);
      return s;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_session();
      step();
      bus.go = 1'b1;
      @(negedge clk);
      chk("start_not_early", int'(bus.trial_start), 0);
      @(negedge clk);
      chk("start_pulse", int'(bus.trial_start), 1);
      chk("busy_rise", int'(bus.busy), 1);
      bus.go = 1'b0;
   endtask

   // Entered at the ARM negedge; returns in the first GAP cycle.
   task automatic run_trial(input int k, input int t);
      step();
      if (k == EARLY) begin
         step();
         bus.resp = 1'b1;
         step();
         bus.resp = 1'b0;
      end else begin
         step();
         bus.delay_done = 1'b1;
         step();
         bus.delay_done = 1'b0;
         step();
         if (k == HIT) begin
            bus.act_time = 16'(t - 1);
            bus.resp = 1'b1;
            step();
            bus.act_time = 16'(t);
            step();
            bus.resp = 1'b0;
         end else if (k == MISS) begin
            bus.timeout = 1'b1;
            step();
            bus.timeout = 1'b0;
         end else begin
            bus.act_time = 16'd7;
            bus.resp = 1'b1;
            bus.timeout = 1'b1;
            step();
            bus.resp = 1'b0;
            bus.timeout = 1'b0;
         end
      end
   endtask

   task automatic wait_next(output int n);
      n = 21;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.trial_start || bus.done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_session(input sess_t s);
      int n;
      int e0;
      int exp_last;
      sess_t e;
      exp_last = 0;
      start_session();
      e0 = early_seen;
      exp_q.push_back(s);
      for (int i = 0; i < 4; i++) begin
         chk("trial_idx", int'(bus.trial_idx), i);
         run_trial(int'(s.kind[i]), int'(s.t[i]));
         if (int'(s.kind[i]) == HIT) exp_last = int'(s.t[i]);
         chk("last_after_trial", int'(bus.last_time), exp_last);
         wait_next(n);
         chk("gap_len", n, 5);
      end
      chk("done", int'(bus.done), 1);
      chk("busy_end", int'(bus.busy), 0);
      e = exp_q.pop_front();
      chk("last_time", int'(bus.last_time), int'(e.last));
      chk("best_time", int'(bus.best_time), int'(e.best));
      chk("avg_time", int'(bus.avg_time), int'(e.avg));
      chk("miss_cnt", int'(bus.miss_cnt), int'(e.miss));
      chk("early_pulses", early_seen - e0, int'(e.nearly));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int hits;
      tbl[0] = mk(HIT, 300, HIT, 250, HIT, 400, HIT, 350,
                  350, 250, 325, 0, 0);
      tbl[1] = mk(EARLY, 0, HIT, 200, HIT, 200, HIT, 200,
                  200, 200, 2649, 1, 1);
      tbl[2] = mk(HIT, 500, TIE, 0, HIT, 100, HIT, 300,
                  300, 100, 2724, 1, 0);
      tbl[3] = mk(MISS, 0, MISS, 0, MISS, 0, MISS, 0,
                  0, 65535, 9999, 4, 0);
      tbl[4] = mk(MISS, 0, HIT, 1000, EARLY, 0, HIT, 50,
                  50, 50, 5262, 2, 1);

      bus.go = 1'b0;
      bus.abort = 1'b0;
      bus.resp = 1'b0;
      bus.delay_done = 1'b0;
      bus.timeout = 1'b0;
      bus.act_time = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_early", int'(bus.early), 0);
      chk("rst_start", int'(bus.trial_start), 0);
      chk("rst_idx", int'(bus.trial_idx), 0);
      chk("rst_last", int'(bus.last_time), 0);
      chk("rst_avg", int'(bus.avg_time), 0);
      chk("rst_miss", int'(bus.miss_cnt), 0);
      chk("rst_best", int'(bus.best_time), 65535);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int s = 0; s < NS; s++) run_session(tbl[s]);

      // abort during MEASURE of the second trial
      start_session();
      run_trial(HIT, 300);
      wait_next(n);
      chk("abort_gap_len", n, 5);
      step();
      step();
      bus.delay_done = 1'b1;
      step();
      bus.delay_done = 1'b0;
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_keep_last", int'(bus.last_time), 300);
      repeat (3) @(negedge clk);
      chk("abort_idle_start", int'(bus.trial_start), 0);
      start_session();
      chk("restart_idx", int'(bus.trial_idx), 0);
      chk("restart_best", int'(bus.best_time), 65535);
      chk("restart_last", int'(bus.last_time), 0);

      // asynchronous reset in GAP with go held high through release
      run_trial(HIT, 123);
      chk("pre_rst_last", int'(bus.last_time), 123);
      #2;
      rst_n = 1'b0;
      bus.go = 1'b1;
      #1;
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_last", int'(bus.last_time), 0);
      chk("arst_best", int'(bus.best_time), 65535);
      chk("arst_done", int'(bus.done), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      hits = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.trial_start || bus.busy) hits++;
      end
      chk("held_go_no_start", hits, 0);
      bus.go = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
